fast_unsigned_divider: RTL and testbench

- Sequential radix-2 restoring unsigned divider: the inverse of fast_unsigned_multiplier.
- Takes an OUTPUT_LENGTH-bit dividend and an INPUT_LENGTH-bit divisor. Returns an OUTPUT_LENGTH-bit quotient and an INPUT_LENGTH-bit remainder.
- Produces one quotient bit per clock. Uses a start/ready and valid/ready handshake toward the arithmetic datapath.
- Each trial subtraction uses one carry_lookahead_adder instance (WIDTH = INPUT_LENGTH+1, iB = ~divisor, iC = 1).

---
 rtl/fast_unsigned_divider.sv | 171 +++++++++++++++++
 tb/tb_fast_unsigned_divider.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/fast_unsigned_divider.sv
// Sequential radix-2 restoring unsigned divider.
// Produces one quotient bit per clock. Each trial subtraction goes through a
// single carry-lookahead adder, and that adder's carry-out is the borrow flag.
// A zero divisor skips the iteration and returns an all-ones quotient.
//
// state | meaning
// IDLE  | ready for a new operation; operands are sampled on iStart
// CALC  | one restoring iteration per cycle, OUTPUT_LENGTH cycles in total
// DONE  | result is presented until the consumer acknowledges it

module carry_lookahead_adder #(
  parameter int WIDTH = 17
) (
  input  logic [WIDTH-1:0] iA,
  input  logic [WIDTH-1:0] iB,
  input  logic             iC,
  output logic [WIDTH-1:0] oS,
  output logic             oC
);

  logic [WIDTH-1:0] gen;
  logic [WIDTH-1:0] prop;
  logic [WIDTH:0]   carry;

  // Each carry is expanded from the generate/propagate terms and the carry-in,
  // so that no carry depends on the carry computed before it.
  always_comb begin
    logic c_acc;
    gen  = iA & iB;
    prop = iA ^ iB;
    carry = '0;
    for (int i = 0; i <= WIDTH; i++) begin
      c_acc = iC;
      for (int j = 0; j < i; j++) begin
        c_acc = gen[j] | (prop[j] & c_acc);
      end
      carry[i] = c_acc;
    end
    oS = prop ^ carry[WIDTH-1:0];
    oC = carry[WIDTH];
  end

endmodule

module fast_unsigned_divider #(
  parameter int INPUT_LENGTH  = 16,
  parameter int OUTPUT_LENGTH = 32
) (
  input  logic                     iClk,
  input  logic                     iRstN,
  input  logic                     iStart,
  input  logic [OUTPUT_LENGTH-1:0] iA,
  input  logic [INPUT_LENGTH-1:0]  iB,
  output logic                     oReady,
  output logic                     oValid,
  input  logic                     iAck,
  output logic [OUTPUT_LENGTH-1:0] oQuot,
  output logic [INPUT_LENGTH-1:0]  oRem,
  output logic                     oDivZero
);

  localparam int CNT_W = (OUTPUT_LENGTH > 1) ? $clog2(OUTPUT_LENGTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                   state_q, state_d;
  logic [OUTPUT_LENGTH-1:0] quot_q, quot_d;
  logic [INPUT_LENGTH-1:0]  div_q, div_d;
  logic [INPUT_LENGTH-1:0]  rem_q, rem_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     dz_q, dz_d;

  logic [INPUT_LENGTH:0]    trial;
  logic [INPUT_LENGTH:0]    diff;
  logic                     no_borrow;
  logic                     unused_diff_msb;

  // Partial remainder shifted left with the next dividend bit brought in.
  assign trial = {rem_q, quot_q[OUTPUT_LENGTH-1]};

  // trial - divisor as trial + ~divisor + 1; carry-out high means no borrow.
  carry_lookahead_adder #(
    .WIDTH(INPUT_LENGTH + 1)
  ) u_cla (
    .iA(trial),
    .iB(~{1'b0, div_q}),
    .iC(1'b1),
    .oS(diff),
    .oC(no_borrow)
  );

  // When the subtraction succeeds the difference is below the divisor, so its
  // top bit is always zero and the remainder fits in INPUT_LENGTH bits.
  assign unused_diff_msb = diff[INPUT_LENGTH];

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    quot_d  = quot_q;
    div_d   = div_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    dz_d    = dz_q;
    unique case (state_q)
      IDLE: begin
        if (iStart) begin
          div_d = iB;
          cnt_d = CNT_W'(OUTPUT_LENGTH - 1);
          if (iB == '0) begin
            quot_d  = '1;
            rem_d   = iA[INPUT_LENGTH-1:0];
            dz_d    = 1'b1;
            state_d = DONE;
          end else begin
            quot_d  = iA;
            rem_d   = '0;
            dz_d    = 1'b0;
            state_d = CALC;
          end
        end
      end
      CALC: begin
        rem_d  = no_borrow ? diff[INPUT_LENGTH-1:0] : trial[INPUT_LENGTH-1:0];
        quot_d = {quot_q[OUTPUT_LENGTH-2:0], no_borrow};
        if (cnt_q == '0) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
        if (iAck) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any operation in flight.
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      state_q <= IDLE;
      quot_q  <= '0;
      div_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      quot_q  <= quot_d;
      div_q   <= div_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      dz_q    <= dz_d;
    end
  end

  assign oReady   = (state_q == IDLE);
  assign oValid   = (state_q == DONE);
  assign oQuot    = quot_q;
  assign oRem     = rem_q;
  assign oDivZero = dz_q;

endmodule

// File: tb/tb_fast_unsigned_divider.sv
// Randomised self-checking bench for fast_unsigned_divider against a plain
// arithmetic reference (/, %) plus directed handshake and reset cases.

module tb_fast_unsigned_divider;

  localparam int IL = 16;
  localparam int OL = 32;

  logic          iClk = 1'b0;
  logic          iRstN = 1'b0;
  logic          iStart = 1'b0;
  logic [OL-1:0] iA = '0;
  logic [IL-1:0] iB = '0;
  logic          iAck = 1'b0;
  logic          oReady;
  logic          oValid;
  logic [OL-1:0] oQuot;
  logic [IL-1:0] oRem;
  logic          oDivZero;

  int checks = 0;
  int errors = 0;

  fast_unsigned_divider #(
    .INPUT_LENGTH (IL),
    .OUTPUT_LENGTH(OL)
  ) dut (
    .iClk    (iClk),
    .iRstN   (iRstN),
    .iStart  (iStart),
    .iA      (iA),
    .iB      (iB),
    .oReady  (oReady),
    .oValid  (oValid),
    .iAck    (iAck),
    .oQuot   (oQuot),
    .oRem    (oRem),
    .oDivZero(oDivZero)
  );

  always #5 iClk = ~iClk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: ordinary integer division, with the zero-divisor convention.
  task automatic ref_div(input logic [OL-1:0] a, input logic [IL-1:0] b,
                         output logic [OL-1:0] q, output logic [IL-1:0] r,
                         output logic dz, output int lat);
    longint unsigned la, lb;
    la = longint'(a);
    lb = longint'(b);
    if (b == 0) begin
      q   = '1;
      r   = a[IL-1:0];
      dz  = 1'b1;
      lat = 1;
    end else begin
      q   = OL'(la / lb);
      r   = IL'(la % lb);
      dz  = 1'b0;
      lat = OL + 1;
    end
  endtask

  // Issue one operation and count edges from the accepting edge until oValid.
  task automatic run_op(input logic [OL-1:0] a, input logic [IL-1:0] b, output int lat);
    int w;
    w = 0;
    while (!oReady && w < 100) begin
      @(posedge iClk); #1;
      w++;
    end
    iA = a;
    iB = b;
    iStart = 1'b1;
    @(posedge iClk); #1;
    iStart = 1'b0;
    lat = 1;
    while (!oValid && lat < 100) begin
      @(posedge iClk); #1;
      lat++;
    end
  endtask

  task automatic ack_result();
    iAck = 1'b1;
    @(posedge iClk); #1;
    iAck = 1'b0;
  endtask

  task automatic check_result(input string tag, input logic [OL-1:0] a,
                              input logic [IL-1:0] b, input int lat);
    logic [OL-1:0] q;
    logic [IL-1:0] r;
    logic          dz;
    int            elat;
    ref_div(a, b, q, r, dz, elat);
    check_eq({tag, "_lat"}, 64'(lat), 64'(elat));
    check_eq({tag, "_quot"}, 64'(oQuot), 64'(q));
    check_eq({tag, "_rem"}, 64'(oRem), 64'(r));
    check_eq({tag, "_dz"}, 64'(oDivZero), 64'(dz));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int seen;
    logic [OL-1:0] a;
    logic [IL-1:0] b;

    // Reset
    repeat (3) @(posedge iClk);
    #1;
    iRstN = 1'b1;
    @(posedge iClk); #1;
    check_eq("rst_ready", 64'(oReady), 64'd1);
    check_eq("rst_valid", 64'(oValid), 64'd0);
    check_eq("rst_quot", 64'(oQuot), 64'd0);
    check_eq("rst_rem", 64'(oRem), 64'd0);
    check_eq("rst_dz", 64'(oDivZero), 64'd0);

    // Basic divide, held result, then iAck with a competing iStart
    run_op(32'd1000, 16'd7, lat);
    check_eq("basic_valid", 64'(oValid), 64'd1);
    check_result("basic", 32'd1000, 16'd7, lat);
    for (int i = 0; i < 5; i++) begin
      iA = $urandom;
      iB = 16'($urandom);
      @(posedge iClk); #1;
      check_eq("hold_valid", 64'(oValid), 64'd1);
      check_eq("hold_quot", 64'(oQuot), 64'd142);
      check_eq("hold_rem", 64'(oRem), 64'd6);
    end
    iAck = 1'b1;
    iStart = 1'b1;
    iA = 32'd50;
    iB = 16'd3;
    @(posedge iClk); #1;
    iAck = 1'b0;
    iStart = 1'b0;
    check_eq("ack_valid_low", 64'(oValid), 64'd0);
    check_eq("ack_start_ignored", 64'(oReady), 64'd1);
    check_eq("ack_quot_kept", 64'(oQuot), 64'd142);
    check_eq("ack_rem_kept", 64'(oRem), 64'd6);

    // Boundaries and divide by zero
    run_op(32'hFFFF_FFFF, 16'd1, lat);
    check_result("b_div1", 32'hFFFF_FFFF, 16'd1, lat);
    check_eq("b_div1_q", 64'(oQuot), 64'hFFFF_FFFF);
    ack_result();
    run_op(32'hFFFF_FFFF, 16'hFFFF, lat);
    check_eq("b_divmax_q", 64'(oQuot), 64'h0001_0001);
    check_eq("b_divmax_r", 64'(oRem), 64'd0);
    ack_result();
    run_op(32'd5, 16'd9, lat);
    check_eq("b_small_q", 64'(oQuot), 64'd0);
    check_eq("b_small_r", 64'(oRem), 64'd5);
    ack_result();
    run_op(32'h1234_5678, 16'd0, lat);
    check_eq("dz_lat", 64'(lat), 64'd1);
    check_eq("dz_flag", 64'(oDivZero), 64'd1);
    check_eq("dz_quot", 64'(oQuot), 64'hFFFF_FFFF);
    check_eq("dz_rem", 64'(oRem), 64'h5678);
    ack_result();

    // iStart held high with operands changing throughout the calculation
    iA = 32'd1000;
    iB = 16'd7;
    iStart = 1'b1;
    @(posedge iClk); #1;
    lat = 1;
    while (!oValid && lat < 100) begin
      iA = $urandom;
      iB = 16'($urandom);
      @(posedge iClk); #1;
      lat++;
    end
    iStart = 1'b0;
    check_result("abuse", 32'd1000, 16'd7, lat);
    ack_result();

    // Async reset in the middle of CALC
    iA = 32'hDEAD_BEEF;
    iB = 16'd3;
    iStart = 1'b1;
    @(posedge iClk); #1;
    iStart = 1'b0;
    repeat (10) @(posedge iClk);
    #1;
    check_eq("mid_busy", 64'(oReady), 64'd0);
    iRstN = 1'b0;
    #2;
    check_eq("mid_rst_ready", 64'(oReady), 64'd1);
    iRstN = 1'b1;
    seen = 0;
    repeat (40) begin
      @(posedge iClk); #1;
      if (oValid) seen = 1;
    end
    check_eq("mid_no_valid", 64'(seen), 64'd0);
    check_eq("mid_idle", 64'(oReady), 64'd1);
    check_eq("mid_quot_clr", 64'(oQuot), 64'd0);

    // Random operands, including zero and tiny divisors
    for (int n = 0; n < 1000; n++) begin
      case ($urandom_range(0, 15))
        0:       b = '0;
        1:       b = 16'd1;
        2, 3, 4: b = 16'($urandom_range(1, 255));
        default: b = 16'($urandom);
      endcase
      a = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(0, 70000)) : 32'($urandom);
      run_op(a, b, lat);
      check_result("rand", a, b, lat);
      ack_result();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
